// File: rtl/pwm_duty_sequencer_if.sv
`default_nettype none
// ============================================================================
// pwm_duty_sequencer_if : command/status bus of the PWM duty sequencer
// Revision: 1.0
// ============================================================================
interface pwm_duty_sequencer_if #(
  parameter int DW = 7
);
  logic          ena;
  logic          load;
  logic [DW-1:0] target;
  logic          sync_clr;
  logic          xu;
  logic          xd;
  logic          busy;
  logic          done;
  logic [DW-1:0] duty_est;

  modport master (
    output ena, load, target, sync_clr,
    input  xu, xd, busy, done, duty_est
  );

  modport slave (
    input  ena, load, target, sync_clr,
    output xu, xd, busy, done, duty_est
  );
endinterface
`default_nettype wire

// File: rtl/pwm_duty_sequencer.sv
`default_nettype none
// ============================================================================
// pwm_duty_sequencer : walks the PWM duty to a target with timed xu/xd pulses
// Revision: 1.0
// ============================================================================
module pwm_duty_sequencer #(
  parameter int PULSE_LEN = 32,
  parameter int GAP_LEN   = 32,
  parameter int MAX_DUTY  = 100,
  parameter int DW        = 7
) (
  input wire                  clk,
  input wire                  rst,
  pwm_duty_sequencer_if.slave bus
);

  localparam int c_MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int c_CNT_W   = $clog2(c_MAX_LEN + 1);
  localparam logic [c_CNT_W-1:0] c_PULSE_LAST = c_CNT_W'(PULSE_LEN - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST   = c_CNT_W'(GAP_LEN - 1);
  localparam logic [DW-1:0]      c_MAX        = DW'(MAX_DUTY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt,   w_cnt_nxt;
  logic                 r_dir,   w_dir_nxt;
  logic [DW-1:0]        r_duty,  w_duty_nxt;
  logic [DW-1:0]        r_tgt,   w_tgt_nxt;
  logic                 r_xu,    w_xu_nxt;
  logic                 r_xd,    w_xd_nxt;
  logic                 r_busy,  w_busy_nxt;
  logic                 r_done,  w_done_nxt;

  logic [DW-1:0]        w_tgt_clamped;
  logic                 w_up_idle;
  logic                 w_up_gap;

  assign w_tgt_clamped = (bus.target > c_MAX) ? c_MAX : bus.target;
  assign w_up_idle     = (w_tgt_clamped > r_duty);
  assign w_up_gap      = (r_tgt > r_duty);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_duty_nxt  = r_duty;
    w_tgt_nxt   = r_tgt;
    w_xu_nxt    = 1'b0;
    w_xd_nxt    = 1'b0;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;

    // Abort path: a partially issued pulse is never credited to the estimate
    if (bus.sync_clr || !bus.ena) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_busy_nxt  = 1'b0;
      if (bus.sync_clr) begin
        w_duty_nxt = '0;
      end
    end else begin
      if (bus.load) begin
        w_tgt_nxt = w_tgt_clamped;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.load) begin
            w_cnt_nxt = '0;
            if (w_tgt_clamped == r_duty) begin
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt = S_PULSE;
              w_busy_nxt  = 1'b1;
              w_dir_nxt   = w_up_idle;
              w_xu_nxt    = w_up_idle;
              w_xd_nxt    = !w_up_idle;
            end
          end
        end
        S_PULSE: begin
          if (r_cnt == c_PULSE_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_GAP;
            if (r_dir && (r_duty != c_MAX)) begin
              w_duty_nxt = r_duty + DW'(1);
            end else if (!r_dir && (r_duty != '0)) begin
              w_duty_nxt = r_duty - DW'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt + c_CNT_W'(1);
            w_xu_nxt  = r_dir;
            w_xd_nxt  = !r_dir;
          end
        end
        S_GAP: begin
          // End of gap is the only point where a retarget takes effect
          if (r_cnt == c_GAP_LAST) begin
            w_cnt_nxt = '0;
            if (r_duty == r_tgt) begin
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt = S_PULSE;
              w_dir_nxt   = w_up_gap;
              w_xu_nxt    = w_up_gap;
              w_xd_nxt    = !w_up_gap;
            end
          end else begin
            w_cnt_nxt = r_cnt + c_CNT_W'(1);
          end
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_duty  <= '0;
      r_tgt   <= '0;
      r_xu    <= 1'b0;
      r_xd    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_duty  <= w_duty_nxt;
      r_tgt   <= w_tgt_nxt;
      r_xu    <= w_xu_nxt;
      r_xd    <= w_xd_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.xu       = r_xu;
  assign bus.xd       = r_xd;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.duty_est = r_duty;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pwm_duty_sequencer : vector table plus corner sequences with a done scoreboard
// Revision: 1.0
// ============================================================================
module tb_pwm_duty_sequencer;
  localparam int P  = 32;
  localparam int G  = 32;
  localparam int DW = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_duty_sequencer_if #(.DW(DW)) bus ();

  pwm_duty_sequencer #(
    .PULSE_LEN(P),
    .GAP_LEN  (G),
    .MAX_DUTY (100),
    .DW       (DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [DW-1:0] target;
    logic [DW-1:0] exp_duty;
    int            exp_ups;
    int            exp_downs;
    int            exp_lat;
  } vec_t;

  vec_t vecs[6];
  vec_t sb_q[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   since_load = 0;
  int   ups = 0;
  int   downs = 0;
  int   run_len = 0;
  logic prev_xu = 1'b0;
  logic prev_xd = 1'b0;
  bit   width_chk = 1'b1;
  bit   got_done = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: sample 1 time unit after the edge and run the monitor
  task automatic cyc();
    vec_t e;
    @(posedge clk);
    #1;
    since_load++;
    check("xu_xd_exclusive", bus.xu & bus.xd, 0);
    if (bus.xu | bus.xd) begin
      run_len++;
    end else begin
      if ((prev_xu | prev_xd) && width_chk) check("pulse_width", run_len, P);
      run_len = 0;
    end
    if (bus.xu && !prev_xu) ups++;
    if (bus.xd && !prev_xd) downs++;
    prev_xu = bus.xu;
    prev_xd = bus.xd;
    if (bus.done) begin
      got_done = 1'b1;
      if (sb_q.size() == 0) begin
        check("unexpected_done", bus.done, 0);
      end else begin
        e = sb_q.pop_front();
        check("duty_est_at_done", bus.duty_est, e.exp_duty);
        check("done_latency", since_load, e.exp_lat);
        check("up_pulses", ups, e.exp_ups);
        check("down_pulses", downs, e.exp_downs);
        check("busy_at_done", bus.busy, 0);
      end
    end
  endtask

  task automatic drive_load(input logic [DW-1:0] t, input bit fresh);
    bus.target = t;
    bus.load   = 1'b1;
    if (fresh) begin
      since_load = 0;
      ups        = 0;
      downs      = 0;
      width_chk  = 1'b1;
    end
    cyc();
    bus.load = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    got_done = 1'b0;
    for (int i = 0; i < budget && !got_done; i++) cyc();
    check("done_within_budget", got_done, 1);
  endtask

  initial begin
    bus.ena      = 1'b0;
    bus.load     = 1'b0;
    bus.target   = '0;
    bus.sync_clr = 1'b0;

    vecs[0] = '{7'd5,   7'd5,   5,   0,   322};
    vecs[1] = '{7'd2,   7'd2,   0,   3,   194};
    vecs[2] = '{7'd3,   7'd3,   1,   0,   66};
    vecs[3] = '{7'd3,   7'd3,   0,   0,   2};
    vecs[4] = '{7'd120, 7'd100, 97,  0,   6210};
    vecs[5] = '{7'd0,   7'd0,   0,   100, 6402};

    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_xu", bus.xu, 0);
    check("reset_xd", bus.xd, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_duty_est", bus.duty_est, 0);
    rst     = 1'b1;
    bus.ena = 1'b1;
    cyc();

    for (int i = 0; i < 6; i++) begin
      sb_q.push_back(vecs[i]);
      drive_load(vecs[i].target, 1'b1);
      wait_done(7000);
    end

    // Retarget from 10 to 0 while the second up pulse is in flight
    drive_load(7'd10, 1'b1);
    check("busy_rise", bus.busy, 1);
    check("first_pulse_up", bus.xu, 1);
    while (since_load < 80) cyc();
    check("in_second_pulse", bus.xu, 1);
    sb_q.push_back('{7'd0, 7'd0, 2, 2, 258});
    drive_load(7'd0, 1'b0);
    wait_done(1000);

    // ena drop inside a gap, load while disabled, then ena drop inside a pulse
    drive_load(7'd10, 1'b1);
    while (since_load < 40) cyc();
    check("gap_duty_est", bus.duty_est, 1);
    bus.ena = 1'b0;
    cyc();
    check("abort_gap_xu", bus.xu, 0);
    check("abort_gap_busy", bus.busy, 0);
    check("abort_gap_duty_est", bus.duty_est, 1);
    bus.target = 7'd50;
    bus.load   = 1'b1;
    cyc();
    bus.load = 1'b0;
    repeat (3) cyc();
    check("disabled_load_busy", bus.busy, 0);
    check("disabled_load_xu", bus.xu, 0);
    bus.ena = 1'b1;
    cyc();
    drive_load(7'd10, 1'b1);
    while (since_load < 20) cyc();
    check("pulse_before_abort", bus.xu, 1);
    width_chk = 1'b0;
    bus.ena   = 1'b0;
    cyc();
    check("abort_pulse_xu", bus.xu, 0);
    check("abort_pulse_xd", bus.xd, 0);
    check("abort_pulse_busy", bus.busy, 0);
    check("abort_pulse_duty_est", bus.duty_est, 1);
    repeat (70) cyc();
    check("abort_hold_duty_est", bus.duty_est, 1);
    bus.ena = 1'b1;
    cyc();

    // sync_clr wins over a simultaneous load
    drive_load(7'd5, 1'b1);
    while (since_load < 70) cyc();
    check("pre_clr_duty_est", bus.duty_est, 2);
    width_chk    = 1'b0;
    bus.sync_clr = 1'b1;
    bus.load     = 1'b1;
    bus.target   = 7'd9;
    cyc();
    bus.sync_clr = 1'b0;
    bus.load     = 1'b0;
    check("clr_duty_est", bus.duty_est, 0);
    check("clr_busy", bus.busy, 0);
    check("clr_xu", bus.xu, 0);
    repeat (5) cyc();
    check("clr_load_ignored", bus.busy, 0);

    // Asynchronous reset between clock edges during a pulse
    drive_load(7'd4, 1'b1);
    while (since_load < 70) cyc();
    check("pre_rst_duty_est", bus.duty_est, 1);
    check("pre_rst_xu", bus.xu, 1);
    width_chk = 1'b0;
    #3 rst = 1'b0;
    #1;
    check("async_rst_xu", bus.xu, 0);
    check("async_rst_xd", bus.xd, 0);
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_done", bus.done, 0);
    check("async_rst_duty_est", bus.duty_est, 0);
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    sb_q.push_back('{7'd1, 7'd1, 1, 0, 66});
    drive_load(7'd1, 1'b1);
    wait_done(500);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
